// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush scheduler: FSM encoding,
// stall/flush bit positions and a small decode helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_IRQ   = 2'd2
    } state_t;

    // stall vector positions {id_ex, if_id, pc}
    localparam int STL_PC    = 0;
    localparam int STL_IF_ID = 1;
    localparam int STL_ID_EX = 2;

    // flush vector has no PC bit, so pipe registers sit one position lower
    localparam int FL_IF_ID = STL_IF_ID - 1;
    localparam int FL_ID_EX = STL_ID_EX - 1;

    localparam logic [2:0] STALL_ALL = 3'b111;
    localparam logic [1:0] FLUSH_ALL = 2'b11;

    // true when every pipe register is frozen this cycle
    function automatic logic is_full_stall(input logic [2:0] stall);
        return stall == STALL_ALL;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/decision bundle between the pipeline datapath (master) and the
// hold/flush scheduler (slave). Suffixes are from the scheduler's viewpoint.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              jump_req_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              ex_stall_i;
    logic              bus_stall_i;
    logic              irq_req_i;
    logic [ADDR_W-1:0] irq_addr_i;

    logic [2:0]        stall_o;
    logic [1:0]        flush_o;
    logic              pc_wr_o;
    logic [ADDR_W-1:0] pc_next_o;
    logic              irq_ack_o;
    logic              bus_timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output jump_req_i, jump_addr_i, ex_stall_i, bus_stall_i, irq_req_i, irq_addr_i,
        input  stall_o, flush_o, pc_wr_o, pc_next_o, irq_ack_o, bus_timeout_o, stall_cnt_o
    );

    modport slave (
        input  jump_req_i, jump_addr_i, ex_stall_i, bus_stall_i, irq_req_i, irq_addr_i,
        output stall_o, flush_o, pc_wr_o, pc_next_o, irq_ack_o, bus_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Up-counter that stops at MAX instead of wrapping; clr has priority over inc.
module pipe_ctrl_sat_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = (q == MAX);

    // count up on inc, hold at MAX, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hold/flush scheduler for the PC -> IF/ID -> ID/EX pipeline.
// Decision outputs are combinational so a redirect lands on the same edge
// as its request; bus-stall timeout and stall statistics are registered.
//
//  state | meaning
//  RUN   | normal flow, interrupts may be accepted
//  STALL | pipeline frozen by EX or bus; interrupts wait until back in RUN
//  IRQ   | interrupt taken, waiting for the request level to drop
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  ctl
);

    localparam int          TO_W   = 16;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    state_t            state;
    logic              stall_any;
    logic              irq_accept;
    logic [2:0]        stall_d;
    logic [1:0]        flush_d;
    logic              pc_wr_d;
    logic [ADDR_W-1:0] pc_next_d;
    logic              irq_ack_d;

    logic [TO_W-1:0]   to_cnt;
    logic              to_at_max;
    logic              timeout_hit;
    logic              bus_timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_at_max;

    assign stall_any  = ctl.ex_stall_i | ctl.bus_stall_i;
    assign irq_accept = (state == ST_RUN) && ctl.irq_req_i && !ctl.jump_req_i && !stall_any;

    // priority mux: reset flush, then jump, then stall, then interrupt entry
    always_comb begin
        stall_d   = '0;
        flush_d   = '0;
        pc_wr_d   = 1'b0;
        pc_next_d = '0;
        irq_ack_d = 1'b0;
        if (!rst) begin
            flush_d = FLUSH_ALL;
        end else if (ctl.jump_req_i) begin
            pc_wr_d   = 1'b1;
            pc_next_d = ctl.jump_addr_i;
            flush_d   = FLUSH_ALL;
        end else if (stall_any) begin
            stall_d[STL_PC]    = 1'b1;
            stall_d[STL_IF_ID] = 1'b1;
            stall_d[STL_ID_EX] = 1'b1;
        end else if (irq_accept) begin
            irq_ack_d          = 1'b1;
            pc_wr_d            = 1'b1;
            pc_next_d          = ctl.irq_addr_i;
            flush_d[FL_IF_ID]  = 1'b1;
            flush_d[FL_ID_EX]  = 1'b1;
        end
    end

    assign ctl.stall_o   = stall_d;
    assign ctl.flush_o   = flush_d;
    assign ctl.pc_wr_o   = pc_wr_d;
    assign ctl.pc_next_o = pc_next_d;
    assign ctl.irq_ack_o = irq_ack_d;

    // scheduler FSM; IRQ keeps honouring stall/jump without leaving
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!ctl.jump_req_i && stall_any) begin
                        state <= ST_STALL;
                    end else if (irq_accept) begin
                        state <= ST_IRQ;
                    end
                end
                ST_STALL: begin
                    if (ctl.jump_req_i || !stall_any) begin
                        state <= ST_RUN;
                    end
                end
                ST_IRQ: begin
                    if (!ctl.irq_req_i) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    pipe_ctrl_sat_cnt #(
        .W   (TO_W),
        .MAX (TO_MAX)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (ctl.bus_stall_i),
        .clr    (!ctl.bus_stall_i),
        .q      (to_cnt),
        .at_max (to_at_max)
    );

    // flag on the edge where the run length reaches TIMEOUT_CYC, not one later
    assign timeout_hit = ctl.bus_stall_i && (to_at_max || (to_cnt == TO_MAX - TO_W'(1)));

    // sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_timeout <= 1'b0;
        end else if (timeout_hit) begin
            bus_timeout <= 1'b1;
        end
    end

    pipe_ctrl_sat_cnt #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (is_full_stall(stall_d) && !stall_at_max),
        .clr    (1'b0),
        .q      (stall_cnt),
        .at_max (stall_at_max)
    );

    assign ctl.bus_timeout_o = bus_timeout;
    assign ctl.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a scoreboard queue: the driver
// pushes the hand-computed response for each cycle, the monitor pops and
// compares at the falling edge.
module tb_pipe_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 3;
    localparam int TO_CYC = 4;

    typedef struct {
        int          id;
        logic [2:0]  stall;
        logic [1:0]  flush;
        logic        pc_wr;
        logic [31:0] pc_next;
        logic        ack;
        logic        chk_reg;
        logic        tmo;
        logic [2:0]  cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;
    exp_t sb_q[$];

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_if ();

    pipe_ctrl #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // drive one cycle of inputs and queue the response expected during that cycle
    task automatic v(input logic r, input logic j, input logic [31:0] ja,
                     input logic e, input logic b, input logic i,
                     input logic [2:0] es, input logic [1:0] ef, input logic ew,
                     input logic [31:0] en, input logic ea,
                     input logic ck, input logic et, input logic [2:0] ec);
        exp_t x;
        @(posedge clk);
        #1;
        rst                = r;
        bus_if.jump_req_i  = j;
        bus_if.jump_addr_i = ja;
        bus_if.ex_stall_i  = e;
        bus_if.bus_stall_i = b;
        bus_if.irq_req_i   = i;
        x.id      = vec_id;
        x.stall   = es;
        x.flush   = ef;
        x.pc_wr   = ew;
        x.pc_next = en;
        x.ack     = ea;
        x.chk_reg = ck;
        x.tmo     = et;
        x.cnt     = ec;
        sb_q.push_back(x);
        vec_id++;
    endtask

    // monitor: compare whatever the DUT presents against the queued expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                n_checks++;
                if ({bus_if.stall_o, bus_if.flush_o, bus_if.pc_wr_o, bus_if.pc_next_o, bus_if.irq_ack_o}
                    !== {x.stall, x.flush, x.pc_wr, x.pc_next, x.ack}) begin
                    n_fail++;
                    $display("FAIL v%0d decision: got stall=%b flush=%b pc_wr=%b pc_next=%h ack=%b, want stall=%b flush=%b pc_wr=%b pc_next=%h ack=%b",
                             x.id, bus_if.stall_o, bus_if.flush_o, bus_if.pc_wr_o, bus_if.pc_next_o,
                             bus_if.irq_ack_o, x.stall, x.flush, x.pc_wr, x.pc_next, x.ack);
                end
                if (x.chk_reg) begin
                    n_checks++;
                    if ({bus_if.bus_timeout_o, bus_if.stall_cnt_o} !== {x.tmo, x.cnt}) begin
                        n_fail++;
                        $display("FAIL v%0d counters: got timeout=%b stall_cnt=%0d, want timeout=%b stall_cnt=%0d",
                                 x.id, bus_if.bus_timeout_o, bus_if.stall_cnt_o, x.tmo, x.cnt);
                    end
                end
            end
        end
    end

    initial begin
        rst                = 1'b0;
        bus_if.jump_req_i  = 1'b0;
        bus_if.jump_addr_i = '0;
        bus_if.ex_stall_i  = 1'b0;
        bus_if.bus_stall_i = 1'b0;
        bus_if.irq_req_i   = 1'b0;
        bus_if.irq_addr_i  = 32'h80;

        // reset with every request asserted
        v(0, 1, 32'h100, 1, 1, 1,  3'b000, 2'b11, 0, 32'h0, 0,  0, 0, 0);
        v(0, 1, 32'h100, 1, 1, 1,  3'b000, 2'b11, 0, 32'h0, 0,  1, 0, 0);
        v(1, 0, 32'h0,   0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 0, 0);
        // jump beats a concurrent EX stall
        v(1, 1, 32'h100, 1, 0, 0,  3'b000, 2'b11, 1, 32'h100, 0, 1, 0, 0);
        // five-cycle EX stall
        for (int k = 0; k < 5; k++)
            v(1, 0, 32'h0, 1, 0, 0,  3'b111, 2'b00, 0, 32'h0, 0,  1, 0, 3'(k));
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 0, 5);
        // back in RUN: immediate interrupt accept, level held gives one pulse
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b11, 1, 32'h80, 1,  1, 0, 5);
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 5);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 5);
        // interrupt held across a 3-cycle bus stall; counter saturates at 7
        for (int k = 0; k < 3; k++)
            v(1, 0, 32'h0, 0, 1, 1,  3'b111, 2'b00, 0, 32'h0, 0,  1, 0, 3'(5 + k));
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b11, 1, 32'h80, 1,  1, 0, 7);
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        // re-rise gives a new ack; jump and stall honoured while in IRQ
        v(1, 0, 32'h0,   0, 0, 1,  3'b000, 2'b11, 1, 32'h80, 1,  1, 0, 7);
        v(1, 1, 32'h200, 0, 0, 1,  3'b000, 2'b11, 1, 32'h200, 0, 1, 0, 7);
        v(1, 0, 32'h0,   1, 0, 1,  3'b111, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        v(1, 0, 32'h0,   0, 0, 1,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        v(1, 0, 32'h0,   0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        // jump releases STALL, then RUN accepts an interrupt
        v(1, 0, 32'h0,   1, 0, 0,  3'b111, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        v(1, 1, 32'h300, 1, 0, 0,  3'b000, 2'b11, 1, 32'h300, 0, 1, 0, 7);
        v(1, 0, 32'h0,   0, 0, 1,  3'b000, 2'b11, 1, 32'h80, 1,  1, 0, 7);
        v(1, 0, 32'h0,   0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 7);
        // reset, then 6-cycle bus stall: timeout visible after the 4th edge
        v(0, 0, 32'h0, 0, 0, 0,  3'b000, 2'b11, 0, 32'h0, 0,  1, 0, 7);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 0, 0);
        for (int k = 0; k < 6; k++)
            v(1, 0, 32'h0, 0, 1, 0,  3'b111, 2'b00, 0, 32'h0, 0,  1, (k >= 4), 3'(k));
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 1, 6);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 1, 6);
        // only reset clears the sticky timeout
        v(0, 0, 32'h0, 0, 0, 0,  3'b000, 2'b11, 0, 32'h0, 0,  1, 1, 6);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 0, 0);
        // 10-cycle stall: 3-bit counter stops at 7
        for (int k = 0; k < 10; k++)
            v(1, 0, 32'h0, 1, 0, 0,  3'b111, 2'b00, 0, 32'h0, 0,  1, 0, (k > 7) ? 3'd7 : 3'(k));
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 0, 7);
        // reset in the middle of a stall with an interrupt pending
        v(1, 0, 32'h0, 1, 0, 0,  3'b111, 2'b00, 0, 32'h0, 0,  1, 0, 7);
        v(0, 0, 32'h0, 1, 0, 1,  3'b000, 2'b11, 0, 32'h0, 0,  1, 0, 7);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,  1, 0, 0);
        // reset while in IRQ returns to RUN, so the held level is accepted again
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b11, 1, 32'h80, 1,  1, 0, 0);
        v(0, 0, 32'h0, 0, 0, 1,  3'b000, 2'b11, 0, 32'h0, 0,   1, 0, 0);
        v(1, 0, 32'h0, 0, 0, 1,  3'b000, 2'b11, 1, 32'h80, 1,  1, 0, 0);
        v(1, 0, 32'h0, 0, 0, 0,  3'b000, 2'b00, 0, 32'h0, 0,   1, 0, 0);

        for (int k = 0; k < 5 && sb_q.size() != 0; k++)
            @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
